// File: rtl/aurora_tx_framer_pkg.sv
`default_nettype none
// =============================================================================
// aurora_tx_pkg : state encoding, header layout and header builder for the
//                 Aurora TX framer.                          Rev 1.0
// =============================================================================
package aurora_tx_pkg;

  localparam logic [15:0] HDR_MAGIC     = 16'hA5A5;
  localparam int          HDR_W         = 128;
  localparam int          HDR_MAGIC_LSB = 112;
  localparam int          HDR_LEN_LSB   = 96;
  localparam int          HDR_SEQ_LSB   = 64;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    PAY  = 3'd2,
    TRL  = 3'd3,
    DROP = 3'd4
  } state_t;

  function automatic logic [HDR_W-1:0] make_header(input logic [15:0] len,
                                                   input logic [31:0] seq);
    logic [HDR_W-1:0] h;
    h = '0;
    h[HDR_MAGIC_LSB +: 16] = HDR_MAGIC;
    h[HDR_LEN_LSB   +: 16] = len;
    h[HDR_SEQ_LSB   +: 32] = seq;
    return h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aurora_tx_framer_if.sv
`default_nettype none
// =============================================================================
// aurora_tx_framer_if : AXI4-Stream beat bundle with master/slave views.
//                                                            Rev 1.0
// =============================================================================
interface aurora_tx_framer_if #(
  parameter int DATA_W = 128
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/aurora_tx_framer_sync_fifo.sv
`default_nettype none
// =============================================================================
// aurora_tx_sync_fifo : single-clock first-word-fall-through FIFO, DEPTH a
//                       power of two.                        Rev 1.0
// =============================================================================
module aurora_tx_sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] din,
  input  wire logic             pop,
  output logic      [WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
      $error("aurora_tx_sync_fifo: DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // count reaches DEPTH exactly when its top bit sets
  assign full    = count[AW];
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push != do_pop) begin
        count <= do_push ? count + CW'(1) : count - CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/aurora_tx_framer.sv
`default_nettype none
// =============================================================================
// aurora_tx_framer : store-and-forward kernel-to-Aurora TX framer with header,
//                    link-loss drop and optional XOR trailer (AURORA_TX_CHKSUM_EN).  Rev 1.0
// =============================================================================
module aurora_tx_framer
  import aurora_tx_pkg::*;
#(
  parameter int DATA_W     = 128,
  parameter int FIFO_DEPTH = 512,
  parameter int MAX_BEATS  = 256,
  parameter int LEN_DEPTH  = 16
) (
  input  wire logic         ap_clk,
  input  wire logic         ap_rst_n,
  aurora_tx_framer_if.slave  s_axis,
  aurora_tx_framer_if.master m_axis_tx,
  input  wire logic         channel_up,
  output logic [31:0]       pkt_cnt,
  output logic [15:0]       drop_cnt,
  output logic              busy
);

  localparam int BC_W = $clog2(MAX_BEATS + 1);

  generate
    if (FIFO_DEPTH < MAX_BEATS) begin : g_depth_check
      $error("aurora_tx_framer: FIFO_DEPTH must be >= MAX_BEATS");
    end
    if (DATA_W != HDR_W) begin : g_width_check
      $error("aurora_tx_framer: DATA_W must be 128");
    end
  endgenerate

  state_t            state, state_nxt;
  logic [31:0]       seq;
  logic [BC_W-1:0]   bc, bc_next;
  logic              skip_drain, skip_nxt;
  logic              in_ready, in_fire, in_eop;
  logic [DATA_W:0]   dq_dout;
  logic              dq_full, dq_empty, dq_pop;
  logic [15:0]       lq_dout;
  logic              lq_full, lq_empty, lq_pop;
  logic              seq_inc, pkt_inc, drop_inc;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid, tx_last;

  // Ingress: split oversize packets at MAX_BEATS; a length entry exists only
  // once every beat of its packet is already in the data FIFO.
  assign in_ready        = ap_rst_n && !dq_full && !lq_full;
  assign s_axis.tready   = in_ready;
  assign in_fire         = s_axis.tvalid && in_ready;
  assign bc_next         = bc + BC_W'(1);
  assign in_eop          = s_axis.tlast || (bc_next == BC_W'(MAX_BEATS));

  aurora_tx_sync_fifo #(.WIDTH(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_data_fifo (
    .clk(ap_clk), .rst_n(ap_rst_n), .push(in_fire), .din({in_eop, s_axis.tdata}),
    .pop(dq_pop), .dout(dq_dout), .full(dq_full), .empty(dq_empty)
  );

  aurora_tx_sync_fifo #(.WIDTH(16), .DEPTH(LEN_DEPTH)) u_len_fifo (
    .clk(ap_clk), .rst_n(ap_rst_n), .push(in_fire && in_eop), .din(16'(bc_next)),
    .pop(lq_pop), .dout(lq_dout), .full(lq_full), .empty(lq_empty)
  );

`ifdef AURORA_TX_CHKSUM_EN
  logic [DATA_W-1:0] chk;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n || state == HDR) begin
      chk <= '0;
    end else if (state == PAY && dq_pop) begin
      chk <= chk ^ dq_dout[DATA_W-1:0];
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_drain;
    tx_valid  = 1'b0;
    tx_last   = 1'b0;
    tx_data   = '0;
    dq_pop    = 1'b0;
    lq_pop    = 1'b0;
    seq_inc   = 1'b0;
    pkt_inc   = 1'b0;
    drop_inc  = 1'b0;
    unique case (state)
      IDLE: if (!lq_empty && channel_up) state_nxt = HDR;
      HDR: begin
        tx_data  = make_header(lq_dout, seq);
        tx_valid = channel_up;
        // Losing the link here still consumes the sequence number.
        if (!channel_up || m_axis_tx.tready) begin
          lq_pop    = 1'b1;
          seq_inc   = 1'b1;
          skip_nxt  = 1'b0;
          state_nxt = channel_up ? PAY : DROP;
        end
      end
      PAY: begin
        tx_data  = dq_dout[DATA_W-1:0];
        tx_valid = channel_up && !dq_empty;
`ifndef AURORA_TX_CHKSUM_EN
        tx_last  = dq_dout[DATA_W];
`endif
        if (!channel_up) begin
          skip_nxt  = 1'b0;
          state_nxt = DROP;
        end else if (m_axis_tx.tready && !dq_empty) begin
          dq_pop = 1'b1;
          if (dq_dout[DATA_W]) begin
`ifdef AURORA_TX_CHKSUM_EN
            state_nxt = TRL;
`else
            pkt_inc   = 1'b1;
            state_nxt = IDLE;
`endif
          end
        end
      end
      TRL: begin
`ifdef AURORA_TX_CHKSUM_EN
        tx_data  = chk;
        tx_valid = channel_up;
        tx_last  = 1'b1;
        if (!channel_up) begin
          skip_nxt  = 1'b1;
          state_nxt = DROP;
        end else if (m_axis_tx.tready) begin
          pkt_inc   = 1'b1;
          state_nxt = IDLE;
        end
`else
        state_nxt = IDLE;
`endif
      end
      DROP: begin
        if (skip_drain) begin
          drop_inc  = 1'b1;
          skip_nxt  = 1'b0;
          state_nxt = IDLE;
        end else if (!dq_empty) begin
          dq_pop = 1'b1;
          if (dq_dout[DATA_W]) begin
            drop_inc  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state      <= IDLE;
      skip_drain <= 1'b0;
      seq        <= '0;
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
      bc         <= '0;
    end else begin
      state      <= state_nxt;
      skip_drain <= skip_nxt;
      if (seq_inc) seq <= seq + 32'd1;
      if (pkt_inc) pkt_cnt <= pkt_cnt + 32'd1;
      if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (in_fire) bc <= in_eop ? '0 : bc_next;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge ap_clk) begin
    if (ap_rst_n && state == PAY) begin
      assert (!dq_empty);
    end
  end
`endif

  assign m_axis_tx.tdata  = tx_data;
  assign m_axis_tx.tvalid = tx_valid;
  assign m_axis_tx.tlast  = tx_last;
  assign busy             = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aurora_tx_framer.sv
`default_nettype none
// tb_aurora_tx_framer: directed, self-checking bench for aurora_tx_framer.
module tb_aurora_tx_framer;

  logic        clk        = 1'b0;
  logic        ap_rst_n   = 1'b0;
  logic        channel_up = 1'b0;
  logic [31:0] pkt_cnt;
  logic [15:0] drop_cnt;
  logic        busy;

  aurora_tx_framer_if #(.DATA_W(128)) s_if ();
  aurora_tx_framer_if #(.DATA_W(128)) m_if ();

  aurora_tx_framer dut (
    .ap_clk(clk), .ap_rst_n(ap_rst_n), .s_axis(s_if), .m_axis_tx(m_if),
    .channel_up(channel_up), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int           n_checks  = 0;
  int           n_errors  = 0;
  int           viol      = 0;
  bit           timed_out = 1'b0;
  bit           sink_rdy  = 1'b1;
  bit           bp_mode   = 1'b0;
  logic         prev_v    = 1'b0;
  logic         prev_hs   = 1'b0;
  logic [31:0]  exp_seq   = '0;
  logic [128:0] rx[$];

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_checks++;
    n_errors++;
    timed_out = 1'b1;
    $display("FAIL %s: timed out waiting on the DUT", tag);
  endtask

  function automatic logic [127:0] pat(input int pk, input int i);
    return {8'hD0, 24'(pk), 32'(i), 32'hCAFE_0000 ^ 32'(i * 7), 32'(pk * 1000 + i)};
  endfunction

  // Sink: tready either held at sink_rdy or toggling every cycle.
  initial begin
    m_if.tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      m_if.tready = bp_mode ? ~m_if.tready : sink_rdy;
    end
  end

  // Monitor: record beats that will handshake at the coming edge.
  initial forever begin
    @(negedge clk);
    if (ap_rst_n && m_if.tvalid && m_if.tready) rx.push_back({m_if.tlast, m_if.tdata});
    if (ap_rst_n && channel_up && prev_v && !prev_hs && !m_if.tvalid) viol++;
    prev_v  = ap_rst_n && m_if.tvalid;
    prev_hs = m_if.tvalid && m_if.tready;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_pkt(input int pk, input int n, input int off);
    int t;
    for (int i = 0; i < n; i++) begin
      if (timed_out) break;
      s_if.tdata  = pat(pk, off + i);
      s_if.tvalid = 1'b1;
      s_if.tlast  = (i == n - 1);
      t = 0;
      @(negedge clk);
      while (!s_if.tready && !timed_out) begin
        @(negedge clk);
        t++;
        if (t > 5000) timeout("send_beat");
      end
      step();
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic pop_rx(output logic [128:0] e);
    int t;
    t = 0;
    e = '0;
    while (rx.size() == 0 && !timed_out) begin
      step();
      t++;
      if (t > 5000) timeout("rx_beat");
    end
    if (rx.size() > 0) e = rx.pop_front();
  endtask

  task automatic expect_frame(input int pk, input int len, input int off);
    logic [128:0] e;
    logic [127:0] x;
    logic         last;
    x = '0;
    pop_rx(e);
    check("header", e, {1'b0, 16'hA5A5, 16'(len), exp_seq, 64'h0});
    exp_seq++;
    for (int i = 0; i < len; i++) begin
      pop_rx(e);
      x = x ^ pat(pk, off + i);
`ifdef AURORA_TX_CHKSUM_EN
      last = 1'b0;
`else
      last = (i == len - 1);
`endif
      check("payload", e, {last, pat(pk, off + i)});
    end
`ifdef AURORA_TX_CHKSUM_EN
    pop_rx(e);
    check("trailer", e, {1'b1, x});
`endif
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_s_tready", s_if.tready, 0);
    check("rst_m_tvalid", m_if.tvalid, 0);
    check("rst_m_tlast", m_if.tlast, 0);
    check("rst_m_tdata", m_if.tdata, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_busy", busy, 0);
    step();
    ap_rst_n = 1'b1;
    exp_seq  = '0;
  endtask

  initial begin
    logic [128:0] e;
    int t;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tdata  = '0;

    do_reset();
    step(); step();
    @(negedge clk);
    check("idle_s_tready", s_if.tready, 1);
    step();

    // Nominal 3-beat frame
    channel_up = 1'b1;
    send_pkt(1, 3, 0);
    expect_frame(1, 3, 0);
    step(); step();
    @(negedge clk);
    check("nominal_pkt_cnt", pkt_cnt, 1);
    check("nominal_busy", busy, 0);
    step();

    // Reset while a header is waiting on the sink
    sink_rdy = 1'b0;
    step(); step();
    send_pkt(2, 4, 0);
    t = 0;
    @(negedge clk);
    while (!m_if.tvalid && t < 5000) begin @(negedge clk); t++; end
    check("midrst_header", m_if.tdata, {16'hA5A5, 16'd4, exp_seq, 64'h0});
    check("midrst_busy", busy, 1);
    step();
    do_reset();
    check("midrst_rx_empty", rx.size(), 0);
    sink_rdy = 1'b1;
    step(); step();

    // 300 beats split at 256
    send_pkt(3, 300, 0);
    expect_frame(3, 256, 0);
    expect_frame(3, 44, 256);

    // Backpressure 1010...
    bp_mode = 1'b1;
    send_pkt(4, 6, 0);
    expect_frame(4, 6, 0);
    bp_mode = 1'b0;
    step(); step();

    // Link loss on payload beat 2 of 5
    send_pkt(5, 5, 0);
    t = 0;
    while (rx.size() < 2 && t < 5000) begin step(); t++; end
    channel_up = 1'b0;
    @(negedge clk);
    check("linkloss_tvalid", m_if.tvalid, 0);
    repeat (20) step();
    @(negedge clk);
    check("linkloss_rx_cnt", rx.size(), 2);
    check("linkloss_drop_cnt", drop_cnt, 1);
    check("linkloss_busy", busy, 0);
    check("linkloss_pkt_cnt", pkt_cnt, 3);
    pop_rx(e);
    check("linkloss_header", e, {1'b0, 16'hA5A5, 16'd5, exp_seq, 64'h0});
    exp_seq++;
    pop_rx(e);
    check("linkloss_beat0", e, {1'b0, pat(5, 0)});
    step();
    channel_up = 1'b1;
    send_pkt(6, 2, 0);
    expect_frame(6, 2, 0);

    // Fill the data FIFO with the link down, then release
    channel_up = 1'b0;
    step();
    send_pkt(7, 256, 0);
    send_pkt(8, 256, 0);
    @(negedge clk);
    check("full_s_tready", s_if.tready, 0);
    check("full_busy", busy, 0);
    step();
    channel_up = 1'b1;
    send_pkt(9, 1, 0);
    expect_frame(7, 256, 0);
    expect_frame(8, 256, 0);
    expect_frame(9, 1, 0);
    repeat (3) step();
    @(negedge clk);
    check("drain_s_tready", s_if.tready, 1);
    check("final_pkt_cnt", pkt_cnt, 7);
    check("final_drop_cnt", drop_cnt, 1);
    check("final_rx_empty", rx.size(), 0);
    check("tvalid_hold", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
